// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue stage.
//   - 3-bit ALU command encodings (ADD..OR)
//   - default operand/result width and tag width
//   - alu_req_t: one queued request {a, b, cmd, tag} at the default widths
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned ALU_TAGW  = 4;

  localparam logic [2:0] ADD  = 3'd0;
  localparam logic [2:0] SUB  = 3'd1;
  localparam logic [2:0] XOR  = 3'd2;
  localparam logic [2:0] SLT  = 3'd3;
  localparam logic [2:0] AND  = 3'd4;
  localparam logic [2:0] NAND = 3'd5;
  localparam logic [2:0] NOR  = 3'd6;
  localparam logic [2:0] OR   = 3'd7;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
    logic [2:0]           cmd;
    logic [ALU_TAGW-1:0]  tag;
  } alu_req_t;

endpackage

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo: request storage for alu_issue_queue.
// Ports:
//   clk, reset     clock, asynchronous active-high reset (clears pointers and count)
//   push_i         request offered; written when ready_o is high
//   ready_o        count < DEPTH, from registered count only
//   data_i         request to store
//   pop_i          remove head entry (ignored while empty)
//   not_empty_o    count > 0
//   head_o         entry at the read pointer (undefined while empty)
// Pointers are log2(DEPTH) bits and wrap naturally; count spans 0..DEPTH.
module alu_issue_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         req_t = alu_req_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  output logic ready_o,
  input  req_t data_i,
  input  logic pop_i,
  output logic not_empty_o,
  output req_t head_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [PtrW-1:0] wptr_d, wptr_q;
  logic [PtrW-1:0] rptr_d, rptr_q;
  logic [CntW-1:0] count_d, count_q;
  logic            push_en, pop_en;

  req_t mem_q [DEPTH];

  // No pass-through when full: ready depends on registered count alone.
  assign ready_o     = count_q < DepthCnt;
  assign not_empty_o = count_q != '0;
  assign push_en     = push_i && ready_o;
  assign pop_en      = pop_i && not_empty_o;
  assign head_o      = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_en) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (pop_en) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; entries are only observed while count > 0.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: operand issue stage in front of a 32-bit combinational ALU.
// Requests {a, b, cmd, tag} are queued in alu_issue_fifo; the head entry drives the
// ALU from registered state, and the ALU result, flags and head tag are captured into an
// output register with its own valid/ready handshake. One operation per cycle.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   in_valid/in_ready           request handshake; in_a, in_b, in_cmd, in_tag payload
//   alu_operandA/B, alu_command drive to ALU (zeros/ADD while queue is empty)
//   alu_result, alu_carryout, alu_zero, alu_overflow   from ALU
//   out_valid/out_ready         response handshake
//   out_result, out_carryout, out_zero, out_overflow, out_tag   captured response
//   sticky_ovf, sticky_clr      sticky overflow flag and its synchronous clear
// Build option ALU_ISSUE_STICKY_OVF_EN: when defined, sticky_ovf sets on any capture with
// alu_overflow=1 and clears on sticky_clr (clear wins). When undefined, sticky_ovf is 0.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = ALU_TAGW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_cmd,
  input  logic [TAGW-1:0]  in_tag,
  output logic [WIDTH-1:0] alu_operandA,
  output logic [WIDTH-1:0] alu_operandB,
  output logic [2:0]       alu_command,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carryout,
  output logic             out_zero,
  output logic             out_overflow,
  output logic [TAGW-1:0]  out_tag,
  output logic             sticky_ovf,
  input  logic             sticky_clr
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       cmd;
    logic [TAGW-1:0]  tag;
  } issue_req_t;

  issue_req_t in_req, head;
  logic       not_empty;
  logic       fire;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] out_result_d, out_result_q;
  logic             out_carryout_d, out_carryout_q;
  logic             out_zero_d, out_zero_q;
  logic             out_overflow_d, out_overflow_q;
  logic [TAGW-1:0]  out_tag_d, out_tag_q;

  assign in_req = '{a: in_a, b: in_b, cmd: in_cmd, tag: in_tag};

  alu_issue_fifo #(
    .DEPTH (DEPTH),
    .req_t (issue_req_t)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (in_valid),
    .ready_o     (in_ready),
    .data_i      (in_req),
    .pop_i       (fire),
    .not_empty_o (not_empty),
    .head_o      (head)
  );

  // Output register is free if empty or being drained this cycle.
  assign fire = not_empty && (!out_valid_q || out_ready);

  always_comb begin
    alu_operandA = '0;
    alu_operandB = '0;
    alu_command  = ADD;
    if (not_empty) begin
      alu_operandA = head.a;
      alu_operandB = head.b;
      alu_command  = head.cmd;
    end
  end

  always_comb begin
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_carryout_d = out_carryout_q;
    out_zero_d     = out_zero_q;
    out_overflow_d = out_overflow_q;
    out_tag_d      = out_tag_q;
    if (fire) begin
      out_valid_d    = 1'b1;
      out_result_d   = alu_result;
      out_carryout_d = alu_carryout;
      out_zero_d     = alu_zero;
      out_overflow_d = alu_overflow;
      out_tag_d      = head.tag;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_carryout_q <= 1'b0;
      out_zero_q     <= 1'b0;
      out_overflow_q <= 1'b0;
      out_tag_q      <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_carryout_q <= out_carryout_d;
      out_zero_q     <= out_zero_d;
      out_overflow_q <= out_overflow_d;
      out_tag_q      <= out_tag_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_carryout = out_carryout_q;
  assign out_zero     = out_zero_q;
  assign out_overflow = out_overflow_q;
  assign out_tag      = out_tag_q;

`ifdef ALU_ISSUE_STICKY_OVF_EN
  logic sticky_ovf_d, sticky_ovf_q;

  always_comb begin
    sticky_ovf_d = sticky_ovf_q;
    if (fire && alu_overflow) begin
      sticky_ovf_d = 1'b1;
    end
    // Clear takes priority over a same-cycle set.
    if (sticky_clr) begin
      sticky_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_ovf_q <= 1'b0;
    end else begin
      sticky_ovf_q <= sticky_ovf_d;
    end
  end

  assign sticky_ovf = sticky_ovf_q;
`else
  logic unused_sticky_clr;

  assign unused_sticky_clr = sticky_clr;
  assign sticky_ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed bench for alu_issue_queue wired to a behavioural model of
// the team 32-bit ALU. Expected values are hand-computed constants.
module tb_alu_issue_queue;
  import alu_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned TW = 4;

`ifdef ALU_ISSUE_STICKY_OVF_EN
  localparam logic StickyExp = 1'b1;
`else
  localparam logic StickyExp = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [2:0]    in_cmd = '0;
  logic [TW-1:0] in_tag = '0;
  logic [W-1:0]  alu_operandA, alu_operandB;
  logic [2:0]    alu_command;
  logic [W-1:0]  alu_result;
  logic          alu_carryout, alu_zero, alu_overflow;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_result;
  logic          out_carryout, out_zero, out_overflow;
  logic [TW-1:0] out_tag;
  logic          sticky_ovf;
  logic          sticky_clr = 1'b0;

  always #5 clk = ~clk;

  alu_issue_queue #(
    .WIDTH (W),
    .DEPTH (D),
    .TAGW  (TW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_cmd       (in_cmd),
    .in_tag       (in_tag),
    .alu_operandA (alu_operandA),
    .alu_operandB (alu_operandB),
    .alu_command  (alu_command),
    .alu_result   (alu_result),
    .alu_carryout (alu_carryout),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carryout (out_carryout),
    .out_zero     (out_zero),
    .out_overflow (out_overflow),
    .out_tag      (out_tag),
    .sticky_ovf   (sticky_ovf),
    .sticky_clr   (sticky_clr)
  );

  // Behavioural team ALU.
  logic [W:0] alu_sum;
  always_comb begin
    alu_sum      = '0;
    alu_result   = '0;
    alu_carryout = 1'b0;
    alu_overflow = 1'b0;
    case (alu_command)
      ADD: begin
        alu_sum      = {1'b0, alu_operandA} + {1'b0, alu_operandB};
        alu_result   = alu_sum[W-1:0];
        alu_carryout = alu_sum[W];
        alu_overflow = (alu_operandA[W-1] == alu_operandB[W-1]) &&
                       (alu_sum[W-1] != alu_operandA[W-1]);
      end
      SUB: begin
        alu_sum      = {1'b0, alu_operandA} + {1'b0, ~alu_operandB} + 33'd1;
        alu_result   = alu_sum[W-1:0];
        alu_carryout = alu_sum[W];
        alu_overflow = (alu_operandA[W-1] != alu_operandB[W-1]) &&
                       (alu_sum[W-1] != alu_operandA[W-1]);
      end
      XOR:  alu_result = alu_operandA ^ alu_operandB;
      SLT:  alu_result = {31'b0, $signed(alu_operandA) < $signed(alu_operandB)};
      AND:  alu_result = alu_operandA & alu_operandB;
      NAND: alu_result = ~(alu_operandA & alu_operandB);
      NOR:  alu_result = ~(alu_operandA | alu_operandB);
      default: alu_result = alu_operandA | alu_operandB;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] cmd,
                      input logic [TW-1:0] tag);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cmd   = cmd;
    in_tag   = tag;
    check("send_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Wrap-test vectors: a, b, cmd, expected result; tag = index.
  logic [W-1:0] va [14];
  logic [W-1:0] vb [14];
  logic [2:0]   vc [14];
  logic [W-1:0] vr [14];

  logic [2:0]   t4_cmd [6];
  logic [W-1:0] t4_res [5];
  logic         t4_rdy [6];

  bit mon_en  = 1'b0;
  int mon_idx = 0;

  // Responses are checked at the negedge before the edge that hands them over.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (mon_idx < 14) begin
        check($sformatf("t6_result%0d", mon_idx), out_result, vr[mon_idx]);
        check($sformatf("t6_tag%0d", mon_idx), 32'(out_tag), 32'(mon_idx));
      end else begin
        check("t6_extra_response", 32'(mon_idx), 32'd13);
      end
      mon_idx++;
    end
  end

  initial begin
    va[0]  = 32'd1;        vb[0]  = 32'd2;        vc[0]  = ADD;  vr[0]  = 32'd3;
    va[1]  = 32'd10;       vb[1]  = 32'd3;        vc[1]  = SUB;  vr[1]  = 32'd7;
    va[2]  = 32'hF0;       vb[2]  = 32'hFF;       vc[2]  = XOR;  vr[2]  = 32'h0F;
    va[3]  = 32'd3;        vb[3]  = 32'd2;        vc[3]  = SLT;  vr[3]  = 32'd0;
    va[4]  = 32'hC;        vb[4]  = 32'hA;        vc[4]  = AND;  vr[4]  = 32'h8;
    va[5]  = 32'hFFFFFFFF; vb[5]  = 32'hFFFFFFFF; vc[5]  = NAND; vr[5]  = 32'h0;
    va[6]  = 32'h0;        vb[6]  = 32'h0;        vc[6]  = NOR;  vr[6]  = 32'hFFFFFFFF;
    va[7]  = 32'h100;      vb[7]  = 32'h001;      vc[7]  = OR;   vr[7]  = 32'h101;
    va[8]  = 32'd100;      vb[8]  = 32'd200;      vc[8]  = ADD;  vr[8]  = 32'd300;
    va[9]  = 32'd5;        vb[9]  = 32'd7;        vc[9]  = SUB;  vr[9]  = 32'hFFFFFFFE;
    va[10] = 32'hFFFFFFFF; vb[10] = 32'd1;        vc[10] = SLT;  vr[10] = 32'd1;
    va[11] = 32'h55;       vb[11] = 32'hAA;       vc[11] = XOR;  vr[11] = 32'hFF;
    va[12] = 32'hFF00;     vb[12] = 32'h0FF0;     vc[12] = AND;  vr[12] = 32'h0F00;
    va[13] = 32'h1000;     vb[13] = 32'h0001;     vc[13] = OR;   vr[13] = 32'h1001;

    t4_cmd[0] = ADD; t4_cmd[1] = SUB; t4_cmd[2] = XOR;
    t4_cmd[3] = AND; t4_cmd[4] = OR;  t4_cmd[5] = ADD;
    t4_res[0] = 32'd10; t4_res[1] = 32'd10; t4_res[2] = 32'd14;
    t4_res[3] = 32'd1;  t4_res[4] = 32'd14;
    t4_rdy[0] = 1'b1; t4_rdy[1] = 1'b1; t4_rdy[2] = 1'b1;
    t4_rdy[3] = 1'b1; t4_rdy[4] = 1'b1; t4_rdy[5] = 1'b0;

    // Reset state
    step();
    step();
    reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_out_flags", 32'({out_carryout, out_zero, out_overflow}), 32'd0);
    check("rst_sticky", 32'(sticky_ovf), 32'd0);
    check("rst_alu_a", alu_operandA, 32'd0);
    check("rst_alu_cmd", 32'(alu_command), 32'(ADD));

    // 2 + 1
    out_ready = 1'b1;
    send(32'd2, 32'd1, ADD, 4'd1);
    check("t1_head_a", alu_operandA, 32'd2);
    check("t1_head_b", alu_operandB, 32'd1);
    step();
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_result", out_result, 32'd3);
    check("t1_flags_c_z_o", 32'({out_carryout, out_zero, out_overflow}), 32'd0);
    check("t1_tag", 32'(out_tag), 32'd1);
    step();
    check("t1_valid_clear", 32'(out_valid), 32'd0);

    // 4 + (-2), then 5 SLT 7
    send(32'd4, 32'hFFFFFFFE, ADD, 4'd2);
    step();
    check("t2_result", out_result, 32'd2);
    check("t2_carry", 32'(out_carryout), 32'd1);
    check("t2_ovf", 32'(out_overflow), 32'd0);
    send(32'd5, 32'd7, SLT, 4'd3);
    step();
    check("t2_slt_result", out_result, 32'd1);
    check("t2_slt_tag", 32'(out_tag), 32'd3);

    // Signed overflow and sticky flag
    send(32'h7FFFFFFF, 32'd1, ADD, 4'd4);
    step();
    check("t3_result", out_result, 32'h80000000);
    check("t3_ovf", 32'(out_overflow), 32'd1);
    check("t3_sticky_set", 32'(sticky_ovf), 32'(StickyExp));
    step();
    check("t3_sticky_hold", 32'(sticky_ovf), 32'(StickyExp));
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    check("t3_sticky_clr", 32'(sticky_ovf), 32'd0);
    // Clear coinciding with an overflowing capture
    send(32'h7FFFFFFF, 32'd1, ADD, 4'd5);
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    check("t3_clr_ovf", 32'(out_overflow), 32'd1);
    check("t3_clr_wins", 32'(sticky_ovf), 32'd0);
    step();
    check("t3_idle", 32'(out_valid), 32'd0);

    // Back-pressure: 6 offered, 5 accepted
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_a     = 32'(10 + k);
      in_b     = 32'(k);
      in_cmd   = t4_cmd[k];
      in_tag   = TW'(k);
      check($sformatf("t4_in_ready%0d", k), 32'(in_ready), 32'(t4_rdy[k]));
      step();
    end
    in_valid = 1'b0;
    check("t4_full", 32'(in_ready), 32'd0);
    check("t4_held_valid", 32'(out_valid), 32'd1);
    step();
    step();
    check("t4_held_tag", 32'(out_tag), 32'd0);
    check("t4_held_result", out_result, 32'd10);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_valid%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("t4_tag%0d", k), 32'(out_tag), 32'(k));
      check($sformatf("t4_result%0d", k), out_result, t4_res[k]);
      if (k == 1) check("t4_ready_back", 32'(in_ready), 32'd1);
      step();
    end
    check("t4_no_sixth", 32'(out_valid), 32'd0);

    // Reset with a response held
    out_ready = 1'b0;
    send(32'd1, 32'd1, ADD, 4'd1);
    send(32'd2, 32'd2, ADD, 4'd2);
    send(32'd3, 32'd3, ADD, 4'd3);
    check("t5_valid_before", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("t5_async_clear", 32'(out_valid), 32'd0);
    step();
    reset = 1'b0;
    check("t5_valid_after", 32'(out_valid), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_tag_cleared", 32'(out_tag), 32'd0);
    out_ready = 1'b1;
    step();
    step();
    check("t5_no_stale", 32'(out_valid), 32'd0);
    send(32'd1, 32'd1, ADD, 4'd9);
    check("t5_no_stale_send", 32'(out_valid), 32'd0);
    step();
    check("t5_fresh_valid", 32'(out_valid), 32'd1);
    check("t5_fresh_result", out_result, 32'd2);
    check("t5_fresh_tag", 32'(out_tag), 32'd9);
    step();

    // Push+pop at count = DEPTH-1 across pointer wrap
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(va[k], vb[k], vc[k], TW'(k));
    out_ready = 1'b1;
    mon_en    = 1'b1;
    for (int k = 4; k < 14; k++) begin
      in_valid = 1'b1;
      in_a     = va[k];
      in_b     = vb[k];
      in_cmd   = vc[k];
      in_tag   = TW'(k);
      check($sformatf("t6_in_ready%0d", k), 32'(in_ready), 32'd1);
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("t6_response_count", 32'(mon_idx), 32'd14);
    check("t6_drained", 32'(out_valid), 32'd0);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
